// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: state encoding,
// stage-control bundle and bubble encoding.
package riscv_hazard_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // ADDI x0, x0, 0 -- what a flushed stage register carries.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RUN,
    ST_DMEM_WAIT,
    ST_REDIR_PEND,
    ST_DRAIN,
    ST_HALTED,
    ST_FAULT
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic pc_sel;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam stage_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam stage_ctrl_t CTRL_INIT   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/riscv_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. master = datapath side, slave = controller.
interface riscv_hazard_ctrl_if;
  import riscv_hazard_ctrl_pkg::*;

  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic              i_id_rs1_used;
  logic              i_id_rs2_used;
  logic [REG_AW-1:0] i_ex_rd;
  logic              i_ex_is_load;
  logic              i_ex_redirect;
  logic [XLEN-1:0]   i_ex_redirect_pc;
  logic              i_imem_ready;
  logic              i_dmem_req;
  logic              i_dmem_ready;
  logic              i_halt_req;

  logic              o_pc_en;
  logic              o_ifid_en;
  logic              o_idex_en;
  logic              o_exmem_en;
  logic              o_memwb_en;
  logic              o_ifid_flush;
  logic              o_idex_flush;
  logic              o_pc_sel;
  logic [XLEN-1:0]   o_pc_redirect;
  logic              o_halt_ack;
  logic              o_dmem_timeout;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_ex_rd, i_ex_is_load,
           i_ex_redirect, i_ex_redirect_pc, i_imem_ready, i_dmem_req, i_dmem_ready, i_halt_req,
    input  o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en, o_ifid_flush, o_idex_flush,
           o_pc_sel, o_pc_redirect, o_halt_ack, o_dmem_timeout
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_ex_rd, i_ex_is_load,
           i_ex_redirect, i_ex_redirect_pc, i_imem_ready, i_dmem_req, i_dmem_ready, i_halt_req,
    output o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en, o_ifid_flush, o_idex_flush,
           o_pc_sel, o_pc_redirect, o_halt_ack, o_dmem_timeout
  );

endinterface

// File: rtl/riscv_hazard_ctrl_detect.sv
// Load-use compare of ID source registers against the EX load destination.
// Kept standalone so forwarding logic can reuse the same match.
module riscv_hazard_detect
  import riscv_hazard_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0][REG_AW-1:0] i_src_idx,
  input  logic [NUM_SRC-1:0]             i_src_used,
  input  logic [REG_AW-1:0]              i_ex_rd,
  input  logic                           i_ex_is_load,
  output logic                           o_load_use
);

  logic [NUM_SRC-1:0] hit;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign hit[g] = i_src_used[g] & (i_src_idx[g] == i_ex_rd);
  end

  // x0 never carries a dependency.
  assign o_load_use = i_ex_is_load & (i_ex_rd != '0) & (|hit);

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Stage enable/flush controller for the 5-stage RV32I pipeline: load-use,
// imem/dmem waits, branch redirects (held across fetch stalls) and halt drain.
module riscv_hazard_ctrl
  import riscv_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_MAX_CYCLES = 255,
  parameter int unsigned DRAIN_CYCLES     = 3
) (
  input logic                i_clk,
  input logic                i_rstn,
  riscv_hazard_ctrl_if.slave hz
);

  state_e          state_q, state_d;
  logic [7:0]      stall_cnt_q, stall_cnt_d;
  logic [2:0]      drain_cnt_q, drain_cnt_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic            halt_ack_q, halt_ack_d;
  logic            timeout_q, timeout_d;

  stage_ctrl_t     ctrl;
  logic            redir_bypass;
  logic            load_use;
  logic            dmem_stall;
  logic [8:0]      stall_next;

  riscv_hazard_detect #(.NUM_SRC(2)) u_detect (
    .i_src_idx    ({hz.i_id_rs2, hz.i_id_rs1}),
    .i_src_used   ({hz.i_id_rs2_used, hz.i_id_rs1_used}),
    .i_ex_rd      (hz.i_ex_rd),
    .i_ex_is_load (hz.i_ex_is_load),
    .o_load_use   (load_use)
  );

  assign dmem_stall = hz.i_dmem_req & ~hz.i_dmem_ready;
  // The stall cycle seen in RUN is wait cycle 1.
  assign stall_next = (state_q == ST_RUN) ? 9'd1 : {1'b0, stall_cnt_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    redir_d      = redir_q;
    halt_ack_d   = halt_ack_q;
    timeout_d    = timeout_q;
    ctrl         = CTRL_FREEZE;
    redir_bypass = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        ctrl    = CTRL_INIT;
        state_d = ST_RUN;
      end

      // A DMEM_WAIT cycle that sees ready behaves exactly like a RUN cycle.
      ST_RUN, ST_DMEM_WAIT: begin
        if (dmem_stall) begin
          ctrl        = CTRL_FREEZE;
          stall_cnt_d = stall_next[7:0];
          if (stall_next >= 9'(STALL_MAX_CYCLES)) begin
            timeout_d = 1'b1;
            state_d   = ST_FAULT;
          end else begin
            state_d   = ST_DMEM_WAIT;
          end
        end else begin
          ctrl    = CTRL_RUN;
          state_d = ST_RUN;
          if (hz.i_ex_redirect) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            if (hz.i_imem_ready) begin
              ctrl.pc_sel  = 1'b1;
              redir_bypass = 1'b1;
            end else begin
              ctrl.pc_en = 1'b0;
              redir_d    = hz.i_ex_redirect_pc;
              state_d    = ST_REDIR_PEND;
            end
          end else if (load_use) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
          end else if (!hz.i_imem_ready) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
          end else if (hz.i_halt_req) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
            drain_cnt_d     = 3'd1;
            state_d         = ST_DRAIN;
          end
        end
      end

      ST_REDIR_PEND: begin
        ctrl            = CTRL_RUN;
        ctrl.pc_sel     = 1'b1;
        ctrl.ifid_flush = 1'b1;
        ctrl.pc_en      = hz.i_imem_ready;
        if (hz.i_imem_ready) state_d = ST_RUN;
      end

      ST_DRAIN: begin
        if (dmem_stall) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl            = CTRL_RUN;
          ctrl.pc_en      = 1'b0;
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
          if (drain_cnt_q >= 3'(DRAIN_CYCLES)) begin
            halt_ack_d = 1'b1;
            state_d    = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q + 3'd1;
          end
        end
      end

      ST_HALTED: begin
        ctrl = CTRL_FREEZE;
        if (!hz.i_halt_req) begin
          halt_ack_d = 1'b0;
          state_d    = ST_RUN;
        end
      end

      ST_FAULT: ctrl = CTRL_FREEZE;

      default: begin
        ctrl    = CTRL_INIT;
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_INIT;
      stall_cnt_q <= '0;
      drain_cnt_q <= '0;
      redir_q     <= '0;
      halt_ack_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      redir_q     <= redir_d;
      halt_ack_q  <= halt_ack_d;
      timeout_q   <= timeout_d;
    end
  end

  assign hz.o_pc_en        = ctrl.pc_en;
  assign hz.o_ifid_en      = ctrl.ifid_en;
  assign hz.o_idex_en      = ctrl.idex_en;
  assign hz.o_exmem_en     = ctrl.exmem_en;
  assign hz.o_memwb_en     = ctrl.memwb_en;
  assign hz.o_ifid_flush   = ctrl.ifid_flush;
  assign hz.o_idex_flush   = ctrl.idex_flush;
  assign hz.o_pc_sel       = ctrl.pc_sel;
  assign hz.o_pc_redirect  = redir_bypass ? hz.i_ex_redirect_pc : redir_q;
  assign hz.o_halt_ack     = halt_ack_q;
  assign hz.o_dmem_timeout = timeout_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the control rules.
module tb_riscv_hazard_ctrl;

  localparam int unsigned SMAX  = 4;
  localparam int unsigned DRAIN = 3;

  typedef struct packed {
    bit [4:0]  en;   // pc, ifid, idex, exmem, memwb
    bit [1:0]  fl;   // ifid, idex
    bit        sel;
    bit [31:0] tgt;
    bit        ack;
    bit        tmo;
  } exp_t;

  typedef struct packed {
    bit          fresh;
    bit          pend;
    bit          halted;
    bit          fault;
    bit          ack;
    bit          tmo;
    int unsigned wait_n;
    int unsigned drain_n;
    bit [31:0]   ptgt;
  } ms_t;

  localparam ms_t MS_RST = '{fresh: 1'b1, default: '0};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_hazard_ctrl_if bus ();

  riscv_hazard_ctrl #(.STALL_MAX_CYCLES(SMAX), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .hz     (bus)
  );

  int    total = 0;
  int    bad   = 0;
  bit    chk_on = 1'b0;
  bit    lit_on = 1'b0;
  bit    lit_tchk = 1'b0;
  exp_t  lit;
  string lit_nm = "";
  ms_t   ms = MS_RST;

  // Expected outputs for the current cycle and the model's next state.
  function automatic void model(input ms_t s, output exp_t e, output ms_t n);
    bit lu, dstall;
    n      = s;
    e.en   = 5'b11111;
    e.fl   = 2'b00;
    e.sel  = 1'b0;
    e.tgt  = s.ptgt;
    e.ack  = s.ack;
    e.tmo  = s.tmo;
    dstall = bus.i_dmem_req && !bus.i_dmem_ready;
    lu = bus.i_ex_is_load && (bus.i_ex_rd != 5'd0) &&
         ((bus.i_id_rs1_used && bus.i_id_rs1 == bus.i_ex_rd) ||
          (bus.i_id_rs2_used && bus.i_id_rs2 == bus.i_ex_rd));
    if (s.fresh) begin
      e.en = 5'b0; e.fl = 2'b11; n.fresh = 1'b0;
    end else if (s.fault) begin
      e.en = 5'b0;
    end else if (s.halted) begin
      e.en = 5'b0;
      if (!bus.i_halt_req) begin n.halted = 1'b0; n.ack = 1'b0; end
    end else if (s.pend) begin
      e.sel = 1'b1; e.fl = 2'b10; e.en[4] = bus.i_imem_ready;
      if (bus.i_imem_ready) n.pend = 1'b0;
    end else if (s.drain_n != 0) begin
      if (dstall) e.en = 5'b0;
      else begin
        e.en[4] = 1'b0; e.fl = 2'b11;
        if (s.drain_n >= DRAIN) begin n.drain_n = 0; n.halted = 1'b1; n.ack = 1'b1; end
        else n.drain_n = s.drain_n + 1;
      end
    end else if (dstall) begin
      e.en = 5'b0;
      n.wait_n = s.wait_n + 1;
      if (n.wait_n >= SMAX) begin n.fault = 1'b1; n.tmo = 1'b1; end
    end else begin
      n.wait_n = 0;
      if (bus.i_ex_redirect) begin
        e.fl = 2'b11;
        if (bus.i_imem_ready) begin e.sel = 1'b1; e.tgt = bus.i_ex_redirect_pc; end
        else begin e.en[4] = 1'b0; n.pend = 1'b1; n.ptgt = bus.i_ex_redirect_pc; end
      end else if (lu) begin
        e.en[4:3] = 2'b00; e.fl = 2'b01;
      end else if (!bus.i_imem_ready) begin
        e.en[4] = 1'b0; e.fl = 2'b10;
      end else if (bus.i_halt_req) begin
        e.en[4] = 1'b0; e.fl = 2'b10; n.drain_n = 1;
      end
    end
  endfunction

  always @(posedge clk or negedge rstn) begin : upd
    exp_t eu;
    ms_t  nu;
    if (!rstn) ms <= MS_RST;
    else begin
      model(ms, eu, nu);
      ms <= nu;
    end
  end

  always @(negedge clk) begin : cmp
    exp_t        e;
    ms_t         nx;
    logic [41:0] dv, mask;
    if (chk_on) begin
      model(ms, e, nx);
      dv = {bus.o_pc_en, bus.o_ifid_en, bus.o_idex_en, bus.o_exmem_en, bus.o_memwb_en,
            bus.o_ifid_flush, bus.o_idex_flush, bus.o_pc_sel, bus.o_pc_redirect,
            bus.o_halt_ack, bus.o_dmem_timeout};
      total++;
      if (dv !== 42'(e)) begin
        bad++;
        $display("FAIL model t=%0t dut=%h exp=%h", $time, dv, e);
      end
      if (lit_on) begin
        mask = {8'hff, {32{lit_tchk}}, 2'b11};
        total++;
        if ((dv & mask) !== (42'(lit) & mask)) begin
          bad++;
          $display("FAIL %s t=%0t dut=%h exp=%h", lit_nm, $time, dv & mask, 42'(lit) & mask);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    lit_on = 1'b0;
  endtask

  task automatic idle();
    bus.i_id_rs1 = '0; bus.i_id_rs2 = '0; bus.i_id_rs1_used = 1'b0; bus.i_id_rs2_used = 1'b0;
    bus.i_ex_rd = '0; bus.i_ex_is_load = 1'b0; bus.i_ex_redirect = 1'b0;
    bus.i_ex_redirect_pc = '0; bus.i_imem_ready = 1'b1; bus.i_dmem_req = 1'b0;
    bus.i_dmem_ready = 1'b0; bus.i_halt_req = 1'b0;
  endtask

  task automatic lx(string nm, bit [4:0] en, bit [1:0] fl, bit sel, bit ack, bit tmo,
                    bit tchk = 1'b0, bit [31:0] tgt = 32'h0);
    lit      = '{en: en, fl: fl, sel: sel, tgt: tgt, ack: ack, tmo: tmo};
    lit_tchk = tchk;
    lit_nm   = nm;
    lit_on   = 1'b1;
  endtask

  initial begin
    bit halt_lvl;
    idle();
    chk_on = 1'b1;
    #2;
    lx("reset", 5'b00000, 2'b11, 0, 0, 0, 1, 32'h0);
    tick(); rstn = 1'b1;
    lx("init_after_release", 5'b00000, 2'b11, 0, 0, 0);
    tick(); lx("run_idle", 5'b11111, 2'b00, 0, 0, 0);

    // load-use, then the rd=x0 case that must not stall
    tick(); bus.i_ex_is_load = 1; bus.i_ex_rd = 5; bus.i_id_rs1 = 5; bus.i_id_rs1_used = 1;
    lx("load_use", 5'b00111, 2'b01, 0, 0, 0);
    tick(); idle(); lx("after_load_use", 5'b11111, 2'b00, 0, 0, 0);
    tick(); bus.i_ex_is_load = 1; bus.i_ex_rd = 0; bus.i_id_rs2 = 0; bus.i_id_rs2_used = 1;
    lx("rd0_no_stall", 5'b11111, 2'b00, 0, 0, 0);

    // redirect while fetch is stalled
    tick(); idle(); bus.i_ex_redirect = 1; bus.i_ex_redirect_pc = 32'h100; bus.i_imem_ready = 0;
    lx("redir_capture", 5'b01111, 2'b11, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); bus.i_imem_ready = 0;
      lx("redir_pend", 5'b01111, 2'b10, 1, 0, 0, 1, 32'h100);
    end
    tick(); idle(); lx("redir_ready", 5'b11111, 2'b10, 1, 0, 0, 1, 32'h100);
    tick(); lx("run_after_redir", 5'b11111, 2'b00, 0, 0, 0);
    tick(); bus.i_ex_redirect = 1; bus.i_ex_redirect_pc = 32'h2000;
    lx("redir_bypass", 5'b11111, 2'b11, 1, 0, 0, 1, 32'h2000);

    // dmem wait holds off a pending redirect
    tick(); idle(); bus.i_dmem_req = 1; bus.i_ex_redirect = 1; bus.i_ex_redirect_pc = 32'h300;
    lx("dmem_wait", 5'b00000, 2'b00, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin tick(); lx("dmem_wait", 5'b00000, 2'b00, 0, 0, 0); end
    tick(); bus.i_dmem_ready = 1;
    lx("redir_after_dmem", 5'b11111, 2'b11, 1, 0, 0, 1, 32'h300);

    // halt: ack DRAIN+1 edges after the request
    tick(); idle(); bus.i_halt_req = 1; lx("halt_accept", 5'b01111, 2'b10, 0, 0, 0);
    for (int i = 0; i < int'(DRAIN); i++) begin tick(); lx("drain", 5'b01111, 2'b11, 0, 0, 0); end
    for (int i = 0; i < 2; i++) begin tick(); lx("halted", 5'b00000, 2'b00, 0, 1, 0); end
    tick(); bus.i_halt_req = 0; lx("halt_release", 5'b00000, 2'b00, 0, 1, 0);
    tick(); lx("resume", 5'b11111, 2'b00, 0, 0, 0);

    // async reset in the middle of a drain
    tick(); bus.i_halt_req = 1;
    tick(); lx("drain", 5'b01111, 2'b11, 0, 0, 0);
    tick(); rstn = 1'b0; #1;
    lx("reset_in_drain", 5'b00000, 2'b11, 0, 0, 0, 1, 32'h0);
    tick(); rstn = 1'b1; idle();
    tick(); lx("run_after_reset", 5'b11111, 2'b00, 0, 0, 0);

    // dmem timeout is fatal and sticky
    for (int i = 0; i < int'(SMAX); i++) begin
      tick(); bus.i_dmem_req = 1; bus.i_dmem_ready = 0;
      lx("dmem_wait_to", 5'b00000, 2'b00, 0, 0, 0);
    end
    tick(); lx("timeout", 5'b00000, 2'b00, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); lx("fault_sticky", 5'b00000, 2'b00, 0, 0, 1);
    end
    tick(); rstn = 1'b0; lx("timeout_cleared", 5'b00000, 2'b11, 0, 0, 0);
    tick(); rstn = 1'b1;

    // randomized traffic against the model
    halt_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rstn = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 19) == 0) halt_lvl = ~halt_lvl;
      bus.i_halt_req       = halt_lvl;
      bus.i_id_rs1         = 5'($urandom_range(0, 3));
      bus.i_id_rs2         = 5'($urandom_range(0, 3));
      bus.i_id_rs1_used    = 1'($urandom_range(0, 1));
      bus.i_id_rs2_used    = 1'($urandom_range(0, 1));
      bus.i_ex_rd          = 5'($urandom_range(0, 3));
      bus.i_ex_is_load     = ($urandom_range(0, 2) == 0);
      bus.i_ex_redirect    = ($urandom_range(0, 7) == 0);
      bus.i_ex_redirect_pc = $urandom;
      bus.i_imem_ready     = ($urandom_range(0, 4) != 0);
      bus.i_dmem_req       = ($urandom_range(0, 2) == 0);
      bus.i_dmem_ready     = ($urandom_range(0, 1) == 0);
    end

    tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_hazard_ctrl.md
Name: riscv_hazard_ctrl

Overview:
Pipeline control block for the 5-stage RV32I core. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves load-use hazards, instruction/data memory wait states, taken-branch redirects and an external halt request. It also holds a pending redirect target across instruction-fetch stalls.

Parameters:
STALL_MAX_CYCLES, 255, consecutive dmem-wait cycles before fatal timeout (range 1..255, 8-bit counter)
DRAIN_CYCLES, 3, cycles to drain the pipeline after halt is accepted (range 1..7)

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_id_rs1  in  5  ID-stage rs1 index
i_id_rs2  in  5  ID-stage rs2 index
i_id_rs1_used  in  1  ID instruction reads rs1
i_id_rs2_used  in  1  ID instruction reads rs2
i_ex_rd  in  5  EX-stage destination index
i_ex_is_load  in  1  EX instruction is a load
i_ex_redirect  in  1  EX resolved a taken branch or jump
i_ex_redirect_pc  in  `XLEN  redirect target
i_imem_ready  in  1  instruction fetch completes this cycle
i_dmem_req  in  1  MEM stage has an outstanding access
i_dmem_ready  in  1  data access completes this cycle
i_halt_req  in  1  level halt request
o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en  out  1 each  stage register enables
o_ifid_flush, o_idex_flush  out  1 each  load a bubble (NOP, valid=0) into the register
o_pc_sel  out  1  PC next = o_pc_redirect
o_pc_redirect  out  `XLEN  redirect target
o_halt_ack  out  1  pipeline drained and frozen
o_dmem_timeout  out  1  sticky fatal flag

Behaviour:
- Reset (async) state INIT:
  - Counters = 0, o_pc_redirect = 0, o_dmem_timeout = 0, o_halt_ack = 0.
  - In INIT all enables = 0, both flushes = 1, o_pc_sel = 0.
  - INIT -> RUN unconditionally on the first edge after reset release.
- States: INIT, RUN, DMEM_WAIT, REDIR_PEND, DRAIN, HALTED, FAULT.
- Default outputs in RUN: all enables 1, flushes 0, o_pc_sel 0.
- RUN priority (highest first):
  1. dmem stall (i_dmem_req & !i_dmem_ready): all enables 0; counter = 1; -> DMEM_WAIT.
  2. redirect (i_ex_redirect):
     - both flushes = 1.
     - If i_imem_ready: o_pc_sel = 1 and o_pc_redirect driven combinationally from i_ex_redirect_pc.
     - Otherwise capture the target into the o_pc_redirect register, set o_pc_en = 0, -> REDIR_PEND.
  3. load-use (i_ex_is_load, i_ex_rd != 0, and rs1_used & rs1 == rd or rs2_used & rs2 == rd): o_pc_en = o_ifid_en = 0, o_idex_flush = 1. Single cycle, stay in RUN.
  4. imem stall (!i_imem_ready): o_pc_en = 0, o_ifid_flush = 1, later stages advance.
  5. halt (i_halt_req with none of the above): o_pc_en = 0, o_ifid_flush = 1; drain counter = 1; -> DRAIN.
- DMEM_WAIT:
  - All enables 0; counter increments each cycle.
  - On i_dmem_ready: enables as RUN for this cycle, -> RUN.
  - If counter reaches STALL_MAX_CYCLES without ready: o_dmem_timeout <= 1, -> FAULT.
- REDIR_PEND:
  - o_pc_sel = 1 with the registered target; o_ifid_flush = 1.
  - o_pc_en = i_imem_ready; -> RUN when i_imem_ready.
  - A new i_ex_redirect here is impossible; the ID/EX flush guarantees it.
- DRAIN:
  - o_pc_en = 0, o_ifid_flush = 1, o_idex_flush = 1.
  - Later stages advance; a dmem stall freezes everything and pauses the counter.
  - Counter reaching DRAIN_CYCLES -> HALTED.
- HALTED: all enables 0, o_halt_ack = 1 (registered). When i_halt_req = 0: o_halt_ack <= 0, -> RUN.
- FAULT: all enables 0; o_dmem_timeout held at 1 until reset.
- Reset mid-operation: immediate return to INIT values; any pending redirect is discarded.
- Enables and flushes are combinational from state + inputs. o_pc_redirect (in REDIR_PEND), o_halt_ack and o_dmem_timeout are registered.

Decomposition:
- Shared package: state encoding constants, NOP bubble encoding, `XLEN (existing riscv_configs).
- Sub-module riscv_hazard_detect: combinational load-use compare, reusable by forwarding logic.
- Counters stay inline.

Test Plan:
- Load-use: ex_is_load = 1, ex_rd = 5, id_rs1 = 5, rs1_used = 1 -> one cycle with pc_en = ifid_en = 0, idex_flush = 1; next cycle all enables 1.
- Load-use with rd = 0: ex_rd = 0, id_rs2 = 0, rs2_used = 1 -> no stall.
- Redirect during imem stall: redirect = 1, target = 0x0000_0100, imem_ready = 0 for 3 cycles -> pc_sel = 1, o_pc_redirect = 0x100, pc_en = 0 for 3 cycles; pc_en = 1 on the ready cycle; RUN next.
- Dmem wait with redirect present: dmem_req = 1, ready = 0 for 4 cycles alongside redirect -> all enables 0 for 4 cycles, redirect honoured only after ready.
- Timeout: STALL_MAX_CYCLES = 4, ready held 0 -> o_dmem_timeout = 1 after the 4th wait cycle; enables stay 0; cleared only by i_rstn low.
- Halt: halt_req = 1 -> halt_ack = 1 exactly DRAIN_CYCLES + 1 edges later; deassert halt_req -> ack drops next edge, RUN resumes. Async reset asserted in DRAIN -> INIT outputs immediately.
